// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with configurable data bits, oversample ratio and stop bits.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clock,
  input  logic                 reset,
  input  logic                 i_rx,
  input  logic                 i_tick,
  input  logic                 i_parity_odd,
  output logic [DATA_BITS-1:0] o_buff_data,
  output logic                 o_flag_rx_done,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             rxSync_q;
  logic                   rxS;
  logic [CW-1:0]          tickCnt_q, tickCnt_d;
  logic [3:0]             bitCnt_q, bitCnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   frameLat_q, frameLat_d;
  logic [DATA_BITS-1:0]   buff_q, buff_d;
  logic                   frameErr_q, frameErr_d;
  logic                   done_q, done_d;
`ifdef UART_RX_PARITY_EN
  logic                   parLat_q, parLat_d;
  logic                   parErr_q, parErr_d;
`else
  logic                   unusedParityOdd;
  assign unusedParityOdd = i_parity_odd;
`endif

  assign rxS = rxSync_q[1];

  // Synchroniser resets to the idle line level so release never looks like a start bit.
  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      rxSync_q   <= 2'b11;
      state_q    <= IDLE;
      tickCnt_q  <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      frameLat_q <= 1'b0;
      buff_q     <= '0;
      frameErr_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parLat_q   <= 1'b0;
      parErr_q   <= 1'b0;
`endif
    end else begin
      rxSync_q   <= {rxSync_q[0], i_rx};
      state_q    <= state_d;
      tickCnt_q  <= tickCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      frameLat_q <= frameLat_d;
      buff_q     <= buff_d;
      frameErr_q <= frameErr_d;
      done_q     <= done_d;
`ifdef UART_RX_PARITY_EN
      parLat_q   <= parLat_d;
      parErr_q   <= parErr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tickCnt_d  = tickCnt_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    frameLat_d = frameLat_q;
    buff_d     = buff_q;
    frameErr_d = frameErr_q;
    done_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    parLat_d   = parLat_q;
    parErr_d   = parErr_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rxS) begin
          state_d    = START;
          tickCnt_d  = '0;
          bitCnt_d   = '0;
          frameLat_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          parLat_d   = 1'b0;
`endif
        end
      end
      // Half a bit in, the line must still be low or the edge was a glitch.
      START: begin
        if (i_tick) begin
          if (tickCnt_q == HALF_LAST) begin
            tickCnt_d = '0;
            state_d   = rxS ? IDLE : DATA;
          end else begin
            tickCnt_d = tickCnt_q + CW'(1);
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (tickCnt_q == FULL_LAST) begin
            tickCnt_d = '0;
            shift_d   = {rxS, shift_q[DATA_BITS-1:1]};
            if (bitCnt_q == DATA_LAST) begin
              bitCnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d  = PARITY;
`else
              state_d  = STOP;
`endif
            end else begin
              bitCnt_d = bitCnt_q + 4'd1;
            end
          end else begin
            tickCnt_d = tickCnt_q + CW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (i_tick) begin
          if (tickCnt_q == FULL_LAST) begin
            tickCnt_d = '0;
            if (rxS != (^shift_q ^ i_parity_odd)) parLat_d = 1'b1;
            state_d   = STOP;
          end else begin
            tickCnt_d = tickCnt_q + CW'(1);
          end
        end
      end
`endif
      // The last stop sample publishes the word and flags even if framing failed.
      STOP: begin
        if (i_tick) begin
          if (tickCnt_q == FULL_LAST) begin
            tickCnt_d = '0;
            if (!rxS) frameLat_d = 1'b1;
            if (bitCnt_q == STOP_LAST) begin
              bitCnt_d   = '0;
              buff_d     = shift_q;
              frameErr_d = frameLat_q | ~rxS;
`ifdef UART_RX_PARITY_EN
              parErr_d   = parLat_q;
`endif
              done_d     = 1'b1;
              state_d    = IDLE;
            end else begin
              bitCnt_d = bitCnt_q + 4'd1;
            end
          end else begin
            tickCnt_d = tickCnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_buff_data    = buff_q;
  assign o_flag_rx_done = done_q;
  assign o_frame_err    = frameErr_q;
  assign o_busy         = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_parity_err   = parErr_q;
`else
  assign o_parity_err   = 1'b0;
`endif

endmodule
